// File: rtl/mux4_rr_sel_ctrl_if.sv
// Handshake bundle between the round-robin select controller and the
// requesters/consumer around mux4to1.
interface mux4_rr_sel_ctrl_if;
  logic [3:0] req_i;
  logic       ready_i;
  logic [1:0] sel_o;
  logic       valid_o;
  logic [3:0] ack_o;
  logic       busy_o;

  // Environment side: drives requests and consumer ready.
  modport master (
    output req_i, ready_i,
    input  sel_o, valid_o, ack_o, busy_o
  );

  // Controller side.
  modport slave (
    input  req_i, ready_i,
    output sel_o, valid_o, ack_o, busy_o
  );
endinterface

// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin select controller for mux4to1. Grants bursts of up to
// MAX_BURST beats per source. Re-arbitration happens in the same edge as
// release, so there is no bubble between back-to-back bursts.
module mux4_rr_sel_ctrl #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4_rr_sel_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       valid;
  logic       beat;
  logic       rel;
  logic [1:0] arb_start;
  logic [1:0] arb_cand;
  logic [1:0] arb_idx;
  logic       arb_hit;

  assign valid = (state_q == GRANT) && bus.req_i[sel_q];
  assign beat  = valid && bus.ready_i;
  assign rel   = (state_q == GRANT) &&
                 (!bus.req_i[sel_q] || (beat && (cnt_q == LAST_BEAT)));

  // While granted the scan only matters on release, where it must start
  // just past the current owner; that is the ptr value being written.
  assign arb_start = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;

  // Round-robin scan: first requester at or after arb_start, modulo 4.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = arb_start;
    arb_cand = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      arb_cand = arb_start + 2'(i);
      if (!arb_hit && bus.req_i[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  // Next-state: grant from IDLE, count beats, release and re-arbitrate.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          sel_d   = arb_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = sel_q + 2'd1;
          if (arb_hit) begin
            sel_d = arb_idx;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.valid_o = valid;
  assign bus.ack_o   = beat ? (4'b0001 << sel_q) : '0;
  assign bus.busy_o  = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_sel_ctrl.sv
// Bench for mux4_rr_sel_ctrl: directed vectors with literal expectations,
// plus a per-cycle comparison against a burst-level round-robin model.
module tb_mux4_rr_sel_ctrl;

  localparam int MB = 4;

  logic clk;
  logic rst_n;

  mux4_rr_sel_ctrl_if bus ();
  mux4_rr_sel_ctrl_if bus1 ();

  assign bus1.req_i   = bus.req_i;
  assign bus1.ready_i = bus.ready_i;

  mux4_rr_sel_ctrl #(.MAX_BURST(MB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux4_rr_sel_ctrl #(.MAX_BURST(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int viol_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Source data presented on the mux inputs; mux4to1 out = in[sel].
  logic [5:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 6'd1;

  function automatic logic [7:0] data_of(input int k);
    return {k[1:0], cyc};
  endfunction

  logic [7:0] mux_out;
  assign mux_out = data_of(int'(bus.sel_o));

  // Burst-level model: owner (-1 when none), beats served, next RR start.
  int m_owner;
  int m_beats;
  int m_ptr;
  int m_sel;
  bit [3:0] pend;

  function automatic int pick(input int start, input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (r[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  initial begin
    logic [3:0] r;
    bit b;
    m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0; pend = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0; pend = '0;
      end else begin
        r = bus.req_i;
        b = (m_owner >= 0) && r[m_owner] && bus.ready_i;
        for (int k = 0; k < 4; k++) begin
          if (pend[k] && !r[k]) begin
            viol_cnt++;
            $display("[TB] protocol violation: source %0d dropped req before ack @%0t", k, $time);
          end
          pend[k] = r[k] && !(b && m_owner == k);
        end
        if (m_owner >= 0) begin
          if (b) m_beats++;
          if (!r[m_owner] || m_beats == MB) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = pick(m_ptr, r);
            m_beats = 0;
            if (m_owner >= 0) m_sel = m_owner;
          end
        end else begin
          m_owner = pick(m_ptr, r);
          if (m_owner >= 0) begin
            m_sel   = m_owner;
            m_beats = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic       ev;
      logic [3:0] ea;
      ev = (m_owner >= 0) && bus.req_i[m_owner];
      ea = (ev && bus.ready_i) ? (4'b0001 << m_owner) : 4'b0000;
      check("m_sel",   32'(bus.sel_o),   32'(m_sel));
      check("m_valid", 32'(bus.valid_o), 32'(ev));
      check("m_ack",   32'(bus.ack_o),   32'(ea));
      check("m_busy",  32'(bus.busy_o),  32'(m_owner >= 0));
      if (ea != 4'b0000)
        check("mux_out", 32'(mux_out), 32'(data_of(m_owner)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = 4'b0000;
    bus.ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_idle_out(input string tag);
    check({tag, "_sel"},   32'(bus.sel_o),   32'd0);
    check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_ack"},   32'(bus.ack_o),   32'd0);
    check({tag, "_busy"},  32'(bus.busy_o),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_i = 4'hF;
    bus.ready_i = 1'b1;
    cmp_en = 1'b1;

    // 1: reset holds outputs cleared despite requests.
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle_out("t1");
    end
    do_reset();

    // 2: sole requester 2, continuous acks across burst boundaries.
    bus.req_i = 4'b0100;
    bus.ready_i = 1'b1;
    step();
    check("t2_sel", 32'(bus.sel_o), 32'd2);
    for (int i = 0; i < 12; i++) begin
      check("t2_ack", 32'(bus.ack_o), 32'h4);
      step();
    end
    do_reset();

    // 3: all requesting, bursts of 4 in RR order; MAX_BURST=1 rotates per beat.
    bus.req_i = 4'b1111;
    bus.ready_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      check("t3_sel",   32'(bus.sel_o),   32'((n / 4) % 4));
      check("t3_valid", 32'(bus.valid_o), 32'd1);
      check("t3_sel1",  32'(bus1.sel_o),  32'(n % 4));
    end
    do_reset();

    // 4: backpressure mid-burst on source 1, then source 3 after 4 beats.
    bus.req_i = 4'b1010;
    bus.ready_i = 1'b1;
    step();
    #1;
    check("t4_sel", 32'(bus.sel_o), 32'd1);
    check("t4_ack", 32'(bus.ack_o), 32'h2);
    step();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_sel",   32'(bus.sel_o),   32'd1);
      check("t4_hold_valid", 32'(bus.valid_o), 32'd1);
      check("t4_hold_ack",   32'(bus.ack_o),   32'd0);
      step();
    end
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_res_ack", 32'(bus.ack_o), 32'h2);
      step();
    end
    #1;
    check("t4_next_sel", 32'(bus.sel_o), 32'd3);
    check("t4_next_ack", 32'(bus.ack_o), 32'h8);
    do_reset();

    // 5: source 0 stops after 2 beats, source 3 waiting.
    bus.req_i = 4'b1001;
    bus.ready_i = 1'b1;
    step();
    #1;
    check("t5_b1", 32'(bus.ack_o), 32'h1);
    step();
    #1;
    check("t5_b2", 32'(bus.ack_o), 32'h1);
    step();
    bus.req_i = 4'b1000;
    #1;
    check("t5_gap_valid", 32'(bus.valid_o), 32'd0);
    step();
    check("t5_sel",   32'(bus.sel_o),   32'd3);
    check("t5_valid", 32'(bus.valid_o), 32'd1);
    do_reset();

    // 6: async reset mid-burst, then scan restarts from 0.
    bus.req_i = 4'b0100;
    bus.ready_i = 1'b1;
    step();
    step();
    #1;
    check("t6_pre_sel", 32'(bus.sel_o), 32'd2);
    rst_n = 1'b0;
    #1;
    check_idle_out("t6_rst");
    bus.req_i = 4'b0110;
    #1;
    rst_n = 1'b1;
    step();
    check("t6_sel",   32'(bus.sel_o),   32'd1);
    check("t6_valid", 32'(bus.valid_o), 32'd1);
    do_reset();

    // 7: request withdrawn before any ack: release, no ack, violation noted.
    bus.req_i = 4'b0001;
    bus.ready_i = 1'b0;
    step();
    check("t7_valid", 32'(bus.valid_o), 32'd1);
    check("t7_ack",   32'(bus.ack_o),   32'd0);
    step();
    bus.req_i = 4'b0000;
    #1;
    check("t7_drop_valid", 32'(bus.valid_o), 32'd0);
    check("t7_drop_ack",   32'(bus.ack_o),   32'd0);
    step();
    check("t7_busy", 32'(bus.busy_o), 32'd0);
    check("t7_viol", 32'(viol_cnt),   32'd1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
